// File: rtl/lcd_arb_pkg.sv
// Shared encodings for the clplcd arbiter: FSM states, command sub-phases,
// one-hot command strobe codes and a couple of handy LCD byte constants.
package lcd_arb_pkg;

  typedef enum logic [2:0] {
    BOOT_I0  = 3'd0,
    BOOT_RST = 3'd1,
    BOOT_I1  = 3'd2,
    BOOT_CLR = 3'd3,
    IDLE     = 3'd4,
    ADDR     = 3'd5,
    DATA     = 3'd6,
    FIN      = 3'd7
  } state_e;

  typedef enum logic [1:0] {
    PH_NONE = 2'd0,
    PH_INIT = 2'd1,
    PH_GAP  = 2'd2,
    PH_HOLD = 2'd3
  } phase_e;

  // Strobe vector order is {datalcd, addrlcd, clearlcd, resetlcd}.
  localparam logic [3:0] CMD_NONE  = 4'b0000;
  localparam logic [3:0] CMD_RESET = 4'b0001;
  localparam logic [3:0] CMD_CLEAR = 4'b0010;
  localparam logic [3:0] CMD_ADDR  = 4'b0100;
  localparam logic [3:0] CMD_DATA  = 4'b1000;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] LCD_LINE2   = 8'h40;

  function automatic logic [3:0] cmd_of(input state_e s);
    case (s)
      BOOT_RST: return CMD_RESET;
      BOOT_CLR: return CMD_CLEAR;
      ADDR:     return CMD_ADDR;
      DATA:     return CMD_DATA;
      default:  return CMD_NONE;
    endcase
  endfunction

endpackage

// File: rtl/lcd_arbiter_if.sv
// Requester and LCD-controller signals of the arbiter; master = arbiter side,
// slave = requesters plus controller.
interface lcd_arbiter_if #(
  parameter int NREQ = 2,
  parameter int LENW = 5
);
  logic [NREQ-1:0]      req;
  logic [8*NREQ-1:0]    reqaddr;
  logic [LENW*NREQ-1:0] reqlen;
  logic [8*NREQ-1:0]    reqchar;
  logic [NREQ-1:0]      charack;
  logic [NREQ-1:0]      done;
  logic [NREQ-1:0]      gnt;
  logic                 initlcd;
  logic                 resetlcd;
  logic                 clearlcd;
  logic                 addrlcd;
  logic                 datalcd;
  logic [7:0]           lcddatin;
  logic                 lcdreset;
  logic                 lcdclear;
  logic                 lcdaddr;
  logic                 lcddata;

  modport master (
    input  req, reqaddr, reqlen, reqchar, lcdreset, lcdclear, lcdaddr, lcddata,
    output charack, done, gnt, initlcd, resetlcd, clearlcd, addrlcd, datalcd, lcddatin
  );

  modport slave (
    output req, reqaddr, reqlen, reqchar, lcdreset, lcdclear, lcdaddr, lcddata,
    input  charack, done, gnt, initlcd, resetlcd, clearlcd, addrlcd, datalcd, lcddatin
  );
endinterface

// File: rtl/lcd_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap.
module lcd_rr_pick #(
  parameter int NREQ = 2,
  parameter int PW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] onehot,
  output logic [PW-1:0]   idx,
  output logic            valid
);

  function automatic logic [PW-1:0] slot(input logic [PW-1:0] p, input int off);
    int s;
    s = int'(p) + off;
    if (s >= NREQ) begin
      s = s - NREQ;
    end else begin
      s = s;
    end
    return PW'(s);
  endfunction

  // Scan from the farthest slot back to ptr so the closest requester wins.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx   = req[slot(ptr, i)] ? slot(ptr, i) : idx;
      valid = valid | req[slot(ptr, i)];
    end
    onehot = valid ? (NREQ'(1'b1) << idx) : '0;
  end

endmodule

// File: rtl/lcd_arbiter.sv
// Round-robin arbiter sharing one clplcd controller; runs LCD bring-up after reset.
// Optional ack timeout with sticky err is enabled by defining LCDARB_TIMEOUT_EN.
module lcd_arbiter
  import lcd_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int LENW = 5,
  parameter int TMO  = 4095
) (
  input  logic          CLK,
  input  logic          RSTN,
  lcd_arbiter_if.master bus,
  output logic          ready,
  output logic          err
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = $clog2(TMO + 1);
`ifdef LCDARB_TIMEOUT_EN
  localparam logic TMO_EN = 1'b1;
`else
  localparam logic TMO_EN = 1'b0;
`endif

  state_e          state_q, state_d;
  phase_e          ph_q, ph_d;
  logic [3:0]      cmd_q, cmd_d;
  logic            init_q, init_d;
  logic [7:0]      dat_q, dat_d;
  logic [NREQ-1:0] gnt_q, gnt_d, done_q, done_d, cack_q, cack_d;
  logic            ready_q, ready_d, err_q, err_d;
  logic [PW-1:0]   ptr_q, ptr_d, idx_q, idx_d;
  logic [7:0]      addr_q, addr_d;
  logic [LENW-1:0] len_q, len_d;
  logic [TW-1:0]   tmo_q, tmo_d;

  logic [NREQ-1:0] pick_oh_s;
  logic [PW-1:0]   pick_idx_s;
  logic            pick_vld_s;
  logic [3:0]      ack_s;
  logic            ack_hit_s, tmo_hit_s;

  lcd_rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req    (bus.req),
    .ptr    (ptr_q),
    .onehot (pick_oh_s),
    .idx    (pick_idx_s),
    .valid  (pick_vld_s)
  );

  // Acks only count while our own strobe is up; anything else is noise.
  assign ack_s     = {bus.lcddata, bus.lcdaddr, bus.lcdclear, bus.lcdreset};
  assign ack_hit_s = (ph_q == PH_HOLD) && ((cmd_q & ack_s) != 4'b0000);
  assign tmo_hit_s = TMO_EN && (ph_q == PH_HOLD) && !ack_hit_s && (tmo_q == TW'(TMO - 1));

  // Next-state: CMD sub-phase sequencing first, then FSM transitions override it.
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    cmd_d   = cmd_q;
    init_d  = 1'b0;
    dat_d   = dat_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    cack_d  = '0;
    ready_d = ready_q;
    err_d   = err_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    len_d   = len_q;
    tmo_d   = '0;

    case (ph_q)
      PH_INIT: ph_d = PH_GAP;
      PH_GAP: begin
        ph_d  = PH_HOLD;
        cmd_d = cmd_of(state_q);
        if (state_q == DATA) begin
          dat_d = bus.reqchar[8*idx_q +: 8];
        end else if (state_q == ADDR) begin
          dat_d = addr_q;
        end else begin
          dat_d = 8'h00;
        end
      end
      PH_HOLD: begin
        if (ack_hit_s || tmo_hit_s) begin
          cmd_d = CMD_NONE;
          ph_d  = PH_NONE;
          err_d = err_q | tmo_hit_s;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      default: ph_d = PH_NONE;
    endcase

    case (state_q)
      BOOT_I0, BOOT_I1: begin
        state_d = (state_q == BOOT_I0) ? BOOT_RST : BOOT_CLR;
        init_d  = 1'b1;
        ph_d    = PH_INIT;
      end
      BOOT_RST, BOOT_CLR: begin
        if (tmo_hit_s || (ack_hit_s && state_q == BOOT_CLR)) begin
          state_d = IDLE;
          ready_d = 1'b1;
        end else if (ack_hit_s) begin
          state_d = BOOT_I1;
        end else begin
          state_d = state_q;
        end
      end
      IDLE: begin
        if (pick_vld_s) begin
          state_d = ADDR;
          idx_d   = pick_idx_s;
          gnt_d   = pick_oh_s;
          addr_d  = bus.reqaddr[8*pick_idx_s +: 8];
          len_d   = bus.reqlen[LENW*pick_idx_s +: LENW];
          init_d  = 1'b1;
          ph_d    = PH_INIT;
        end else begin
          state_d = IDLE;
        end
      end
      ADDR: begin
        if (ack_hit_s && len_q != '0) begin
          state_d = DATA;
          init_d  = 1'b1;
          ph_d    = PH_INIT;
        end else if (ack_hit_s || tmo_hit_s) begin
          state_d = FIN;
        end else begin
          state_d = ADDR;
        end
      end
      DATA: begin
        if (ack_hit_s) begin
          cack_d = gnt_q;
          len_d  = len_q - LENW'(1);
          if (len_q > LENW'(1)) begin
            init_d = 1'b1;
            ph_d   = PH_INIT;
          end else begin
            state_d = FIN;
          end
        end else if (tmo_hit_s) begin
          state_d = FIN;
        end else begin
          state_d = DATA;
        end
      end
      FIN: begin
        done_d  = gnt_q;
        gnt_d   = '0;
        ptr_d   = (idx_q == PW'(NREQ - 1)) ? '0 : idx_q + PW'(1);
        state_d = IDLE;
      end
      default: state_d = BOOT_I0;
    endcase
  end

  // State and registered outputs; reset aborts any transaction without done.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= BOOT_I0;
      ph_q    <= PH_NONE;
      cmd_q   <= CMD_NONE;
      init_q  <= 1'b0;
      dat_q   <= 8'h00;
      gnt_q   <= '0;
      done_q  <= '0;
      cack_q  <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      ptr_q   <= '0;
      idx_q   <= '0;
      addr_q  <= 8'h00;
      len_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      cmd_q   <= cmd_d;
      init_q  <= init_d;
      dat_q   <= dat_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      cack_q  <= cack_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      tmo_q   <= tmo_d;
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.done     = done_q;
  assign bus.charack  = cack_q;
  assign bus.initlcd  = init_q;
  assign bus.resetlcd = cmd_q[0];
  assign bus.clearlcd = cmd_q[1];
  assign bus.addrlcd  = cmd_q[2];
  assign bus.datalcd  = cmd_q[3];
  assign bus.lcddatin = dat_q;
  assign ready        = ready_q;
  assign err          = err_q;

endmodule
